// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin mux select arbiter.
// State encoding and a constant clog2 helper for derived widths.
package rr_mux_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set req bit after ptr, wrapping mod INS.
// Purely combinational; any flags that some request was found.
module rr_priority_pick
  import rr_mux_pkg::*;
#(
  parameter  int INS = 5,
  localparam int SW  = clog2(INS)
) (
  input  logic [INS-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic           any,
  output logic [SW-1:0]  idx
);

  int c;

  // Walk farthest-first so the nearest hit after ptr wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    c   = 0;
    for (int k = INS; k >= 1; k--) begin
      c = int'(ptr) + k;
      if (c >= INS) c = c - INS;
      if (req[c[SW-1:0]]) begin
        any = 1'b1;
        idx = c[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_mux_select_arbiter.sv
// Round-robin arbiter driving the N:1 mux select, grant held until done.
// ARB_TIMEOUT_EN adds a forced release after MAX_HOLD grant cycles.
module rr_mux_select_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int INS      = 5,
  parameter  int MAX_HOLD = 16,
  localparam int SW       = clog2(INS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [INS-1:0] req,
  input  logic           done,
  output logic [SW-1:0]  s,
  output logic [INS-1:0] grant,
  output logic           valid,
  output logic           timeout
);

  localparam logic [INS-1:0] ONE = {{(INS-1){1'b0}}, 1'b1};

  logic           state;
  logic           state_n;
  logic [SW-1:0]  ptr;
  logic [SW-1:0]  ptr_n;
  logic [SW-1:0]  s_n;
  logic [INS-1:0] grant_n;
  logic           valid_n;
  logic           any;
  logic [SW-1:0]  pick;
  logic           expire;
  logic           release_g;

  rr_priority_pick #(.INS(INS)) u_pick (
    .req (req),
    .ptr (ptr),
    .any (any),
    .idx (pick)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt;
  logic          tmo_n;

  assign expire = (cnt == CW'(MAX_HOLD - 1));
  assign tmo_n  = (state == ST_GRANT) && expire && !done;

  // Zero throughout IDLE, so the first GRANT cycle counts from 0.
  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) timeout <= 1'b0;
    else       timeout <= tmo_n;
  end
`else
  logic unused_hold;
  assign unused_hold = (MAX_HOLD > 0);
  assign expire      = 1'b0;
  assign timeout     = 1'b0;
`endif

  assign release_g = done || expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= SW'(INS - 1);
      s     <= '0;
      grant <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      s     <= s_n;
      grant <= grant_n;
      valid <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == ST_IDLE):  if (any)       state_n = ST_GRANT;
      (state == ST_GRANT): if (release_g) state_n = ST_IDLE;
    endcase
  end

  // s is left alone on release so the mux select never glitches.
  always_comb begin
    s_n     = s;
    grant_n = grant;
    valid_n = valid;
    ptr_n   = ptr;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (any) begin
          s_n     = pick;
          grant_n = ONE << pick;
          valid_n = 1'b1;
        end
      end
      (state == ST_GRANT): begin
        if (release_g) begin
          ptr_n   = s;
          grant_n = '0;
          valid_n = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// Directed scoreboard bench for rr_mux_select_arbiter (INS=5).
// Covers ARB_TIMEOUT_EN builds with MAX_HOLD=4.
module tb_rr_mux_select_arbiter;

  typedef struct packed {
    logic [2:0] s;
    logic [4:0] g;
    logic       v;
    logic       t;
  } exp_t;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD   = 4;
  localparam int HOLD_N = 2;
`else
  localparam int HOLD   = 16;
  localparam int HOLD_N = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] req = '0;
  logic       done = 1'b0;
  logic [2:0] s;
  logic [4:0] grant;
  logic       valid;
  logic       timeout;

  int   ncmp = 0;
  int   nerr = 0;
  exp_t sb[$];

  rr_mux_select_arbiter #(.INS(5), .MAX_HOLD(HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .s       (s),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic [4:0] r, input logic d, input logic rs,
                     input logic [2:0] es, input logic [4:0] eg,
                     input logic ev, input logic et);
    exp_t e;
    req   = r;
    done  = d;
    reset = rs;
    sb.push_back('{s: es, g: eg, v: ev, t: et});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("s",       8'(s),       8'(e.s));
    chk("grant",   8'(grant),   8'(e.g));
    chk("valid",   8'(valid),   8'(e.v));
    chk("timeout", 8'(timeout), 8'(e.t));
  endtask

  initial begin
    // reset
    cyc(5'b00000, 1'b0, 1'b1, 3'd0, 5'b00000, 1'b0, 1'b0);
    cyc(5'b00000, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0);

    // req=10101 held, immediate done: 0,2,4,0
    cyc(5'b10101, 1'b0, 1'b0, 3'd0, 5'b00001, 1'b1, 1'b0);
    cyc(5'b10101, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0);
    cyc(5'b10101, 1'b0, 1'b0, 3'd2, 5'b00100, 1'b1, 1'b0);
    cyc(5'b10101, 1'b1, 1'b0, 3'd2, 5'b00000, 1'b0, 1'b0);
    cyc(5'b10101, 1'b0, 1'b0, 3'd4, 5'b10000, 1'b1, 1'b0);
    cyc(5'b10101, 1'b1, 1'b0, 3'd4, 5'b00000, 1'b0, 1'b0);
    cyc(5'b10101, 1'b0, 1'b0, 3'd0, 5'b00001, 1'b1, 1'b0);
    cyc(5'b10101, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0);

    // wrap: ptr=4 then req=00001 -> 0, then req=10000 -> 4
    cyc(5'b10000, 1'b0, 1'b0, 3'd4, 5'b10000, 1'b1, 1'b0);
    cyc(5'b10000, 1'b1, 1'b0, 3'd4, 5'b00000, 1'b0, 1'b0);
    cyc(5'b00001, 1'b0, 1'b0, 3'd0, 5'b00001, 1'b1, 1'b0);
    cyc(5'b00001, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0);
    cyc(5'b10000, 1'b0, 1'b0, 3'd4, 5'b10000, 1'b1, 1'b0);
    cyc(5'b10000, 1'b1, 1'b0, 3'd4, 5'b00000, 1'b0, 1'b0);

    // hold s=3 while req moves to bit 1
    cyc(5'b01000, 1'b0, 1'b0, 3'd3, 5'b01000, 1'b1, 1'b0);
    for (int i = 0; i < HOLD_N; i++)
      cyc(5'b00010, 1'b0, 1'b0, 3'd3, 5'b01000, 1'b1, 1'b0);
    cyc(5'b00010, 1'b1, 1'b0, 3'd3, 5'b00000, 1'b0, 1'b0);
    cyc(5'b00010, 1'b0, 1'b0, 3'd1, 5'b00010, 1'b1, 1'b0);
    cyc(5'b00010, 1'b1, 1'b0, 3'd1, 5'b00000, 1'b0, 1'b0);

    // reset mid-grant, done ignored; then 11111 -> 0
    cyc(5'b00100, 1'b0, 1'b0, 3'd2, 5'b00100, 1'b1, 1'b0);
    cyc(5'b00100, 1'b1, 1'b1, 3'd0, 5'b00000, 1'b0, 1'b0);
    cyc(5'b11111, 1'b0, 1'b0, 3'd0, 5'b00001, 1'b1, 1'b0);
    cyc(5'b11111, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0);

    // done in IDLE is ignored; ptr stays 0 so next pick is 1
    cyc(5'b00000, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0);
    cyc(5'b00000, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0);
    cyc(5'b11111, 1'b0, 1'b0, 3'd1, 5'b00010, 1'b1, 1'b0);
    cyc(5'b11111, 1'b1, 1'b0, 3'd1, 5'b00000, 1'b0, 1'b0);

    // single requester re-granted every other cycle
    for (int i = 0; i < 3; i++) begin
      cyc(5'b00100, 1'b0, 1'b0, 3'd2, 5'b00100, 1'b1, 1'b0);
      cyc(5'b00100, 1'b1, 1'b0, 3'd2, 5'b00000, 1'b0, 1'b0);
    end

`ifdef ARB_TIMEOUT_EN
    // ptr=2, req=00110 -> 1; forced release after 4 cycles, then 2
    cyc(5'b00110, 1'b0, 1'b0, 3'd1, 5'b00010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(5'b00110, 1'b0, 1'b0, 3'd1, 5'b00010, 1'b1, 1'b0);
    cyc(5'b00110, 1'b0, 1'b0, 3'd1, 5'b00000, 1'b0, 1'b1);
    cyc(5'b00110, 1'b0, 1'b0, 3'd2, 5'b00100, 1'b1, 1'b0);
    cyc(5'b00110, 1'b1, 1'b0, 3'd2, 5'b00000, 1'b0, 1'b0);
`else
    // no timeout: grant held well past 16 cycles
    cyc(5'b00110, 1'b0, 1'b0, 3'd1, 5'b00010, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      cyc(5'b00110, 1'b0, 1'b0, 3'd1, 5'b00010, 1'b1, 1'b0);
    cyc(5'b00110, 1'b1, 1'b0, 3'd1, 5'b00000, 1'b0, 1'b0);
    cyc(5'b00110, 1'b0, 1'b0, 3'd2, 5'b00100, 1'b1, 1'b0);
    cyc(5'b00110, 1'b1, 1'b0, 3'd2, 5'b00000, 1'b0, 1'b0);
`endif

    ncmp++;
    assert (sb.size() == 0) else begin
      nerr++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
